// File: rtl/cnn_run_display_ctrl.sv
// Run sequencer for cnn_core: launches inference on a start edge, captures digits into a
// NUM_DISP-deep history shown on active-low 7-seg displays. Optional macro: LATENCY_MEAS_EN.
module cnn_run_display_ctrl #(
    parameter int NUM_DISP       = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16,
    parameter int LAT_W          = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [3:0]            core_digit,
    output logic [7*NUM_DISP-1:0] hex_seg,
    output logic                  busy,
    output logic                  result_valid,
    output logic [CNT_W-1:0]      run_count,
    output logic                  timeout_err,
    output logic [LAT_W-1:0]      last_latency
);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPT} state_e;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

    state_e            state_q;
    logic              start_q;
    logic [3:0]        digit_q;
    logic [WD_W-1:0]   wd_q;
    logic              core_start_q;
    logic              result_valid_q;
    logic [CNT_W-1:0]  run_count_q;
    logic              timeout_err_q;
    // Each slot holds {filled, digit}; an unfilled slot renders blank.
    logic [4:0]        hist_q [NUM_DISP];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            digit_q        <= '0;
            wd_q           <= '0;
            core_start_q   <= 1'b0;
            result_valid_q <= 1'b0;
            run_count_q    <= '0;
            timeout_err_q  <= 1'b0;
            for (int k = 0; k < NUM_DISP; k++) hist_q[k] <= '0;
        end else begin
            start_q        <= start;
            core_start_q   <= 1'b0;
            result_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !start_q) begin
                        state_q       <= S_LAUNCH;
                        core_start_q  <= 1'b1;
                        timeout_err_q <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT;
                    wd_q    <= '0;
                end
                S_WAIT: begin
                    if (core_done) begin
                        state_q <= S_CAPT;
                        digit_q <= core_digit;
                    end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST)) begin
                        state_q       <= S_IDLE;
                        timeout_err_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                S_CAPT: begin
                    state_q        <= S_IDLE;
                    result_valid_q <= 1'b1;
                    run_count_q    <= run_count_q + 1'b1;
                    for (int k = NUM_DISP - 1; k > 0; k--) hist_q[k] <= hist_q[k-1];
                    hist_q[0] <= {1'b1, digit_q};
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [4:0] slot);
        logic [6:0] g;
        g = 7'h7F;
        if (slot[4]) begin
            case (slot[3:0])
                4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
                4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
                4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
                4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
            endcase
        end
        return g;
    endfunction

    always_comb begin
        hex_seg = '0;
        for (int k = 0; k < NUM_DISP; k++) hex_seg[7*k +: 7] = seg7(hist_q[k]);
    end

    assign core_start   = core_start_q;
    assign busy         = (state_q != S_IDLE);
    assign result_valid = result_valid_q;
    assign run_count    = run_count_q;
    assign timeout_err  = timeout_err_q;

`ifdef LATENCY_MEAS_EN
    localparam logic [LAT_W-1:0] LAT_MAX = '1;
    logic [LAT_W-1:0] lat_cnt_q, last_lat_q, lat_inc_d;

    // Saturating +1, shared by the running count and the captured result.
    assign lat_inc_d = (lat_cnt_q == LAT_MAX) ? LAT_MAX : lat_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt_q  <= '0;
            last_lat_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            lat_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            lat_cnt_q <= lat_inc_d;
            if (core_done) last_lat_q <= lat_inc_d;
        end
    end

    assign last_latency = last_lat_q;
`else
    assign last_latency = '0;
`endif

endmodule

// File: tb/tb_cnn_run_display_ctrl.sv
// Directed bench for cnn_run_display_ctrl: one instance with a long watchdog, one with an
// 8-cycle watchdog and 3-bit latency field; tests are run against one instance at a time.
module tb_cnn_run_display_ctrl;
  localparam int ND = 4;
`ifdef LATENCY_MEAS_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a = 1'b0, done_a = 1'b0, start_b = 1'b0, done_b = 1'b0;
  logic [3:0] digit_a = '0, digit_b = '0;
  logic a_cs, a_busy, a_rv, a_to, b_cs, b_busy, b_rv, b_to;
  logic [7*ND-1:0] a_hex, b_hex;
  logic [15:0] a_cnt, b_cnt;
  logic [23:0] a_lat;
  logic [2:0] b_lat;

  cnn_run_display_ctrl #(.NUM_DISP(ND), .TIMEOUT_CYCLES(64), .CNT_W(16), .LAT_W(24)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .core_start(a_cs), .core_done(done_a),
    .core_digit(digit_a), .hex_seg(a_hex), .busy(a_busy), .result_valid(a_rv),
    .run_count(a_cnt), .timeout_err(a_to), .last_latency(a_lat));

  cnn_run_display_ctrl #(.NUM_DISP(ND), .TIMEOUT_CYCLES(8), .CNT_W(16), .LAT_W(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .core_start(b_cs), .core_done(done_b),
    .core_digit(digit_b), .hex_seg(b_hex), .busy(b_busy), .result_valid(b_rv),
    .run_count(b_cnt), .timeout_err(b_to), .last_latency(b_lat));

  int sel = 0;
  logic m_cs, m_busy, m_rv, m_to;
  logic [7*ND-1:0] m_hex;
  logic [15:0] m_cnt;
  logic [23:0] m_lat;
  always_comb begin
    m_cs   = (sel == 0) ? a_cs   : b_cs;
    m_busy = (sel == 0) ? a_busy : b_busy;
    m_rv   = (sel == 0) ? a_rv   : b_rv;
    m_to   = (sel == 0) ? a_to   : b_to;
    m_hex  = (sel == 0) ? a_hex  : b_hex;
    m_cnt  = (sel == 0) ? a_cnt  : b_cnt;
    m_lat  = (sel == 0) ? a_lat  : {21'd0, b_lat};
  end

  // core_start cycles seen at active edges
  int cs_seen = 0;
  always @(posedge clk) if (m_cs) cs_seen++;

  // scoreboard counters
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_start(input logic v);
    if (sel == 0) start_a = v; else start_b = v;
  endtask

  task automatic set_done(input logic v, input logic [3:0] d);
    if (sel == 0) begin done_a = v; digit_a = d; end
    else begin done_b = v; digit_b = d; end
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  function automatic logic [31:0] lat_exp(input int v);
    return LAT_EN ? 32'(v) : 32'd0;
  endfunction

  // One full run: done arrives on WAIT cycle n with digit d.
  task automatic run(input logic [3:0] d, input int n, input logic [7*ND-1:0] exp_hex,
                     input logic [15:0] exp_cnt, input logic [31:0] exp_lat);
    int cs0;
    cs0 = cs_seen;
    @(negedge clk); set_start(1'b1);
    @(negedge clk);
    chk("launch_core_start", m_cs, 1);
    chk("launch_busy", m_busy, 1);
    chk("launch_to_clear", m_to, 0);
    set_start(1'b0);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) chk("wait_core_start_low", m_cs, 0);
      if (k == n) set_done(1'b1, d);
    end
    @(negedge clk); set_done(1'b0, 4'h0);
    chk("capt_busy", m_busy, 1);
    @(negedge clk);
    chk("rv_pulse", m_rv, 1);
    chk("hex_after_run", m_hex, exp_hex);
    chk("run_count", m_cnt, exp_cnt);
    chk("busy_after", m_busy, 0);
    chk("last_latency", m_lat, exp_lat);
    chk("core_start_cycles", cs_seen, cs0 + 1);
    @(negedge clk);
    chk("rv_low", m_rv, 0);
  endtask

  typedef struct {
    logic [3:0]      digit;
    int              wait_n;
    logic [7*ND-1:0] exp_hex;
    logic [15:0]     exp_cnt;
  } vec_t;

  localparam logic [6:0] BL = 7'h7F;

  initial begin
    vec_t vecs[5];
    int cs0, nbusy;
    logic [7*ND-1:0] blank;
    blank = {BL, BL, BL, BL};

    vecs[0] = '{4'h1, 1, {BL, BL, BL, 7'h79}, 16'd1};
    vecs[1] = '{4'h2, 2, {BL, BL, 7'h79, 7'h24}, 16'd2};
    vecs[2] = '{4'h3, 5, {BL, 7'h79, 7'h24, 7'h30}, 16'd3};
    vecs[3] = '{4'h4, 3, {7'h79, 7'h24, 7'h30, 7'h19}, 16'd4};
    vecs[4] = '{4'h5, 1, {7'h24, 7'h30, 7'h19, 7'h12}, 16'd5};

    // reset state
    #1;
    chk("rst_hex_a", a_hex, blank);
    chk("rst_hex_b", b_hex, blank);
    chk("rst_core_start", a_cs, 0);
    chk("rst_rv", a_rv, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_to", a_to, 0);
    chk("rst_lat", a_lat, 0);
    chk("rst_busy", a_busy, 0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;

    // first run: digit 7, done 3 cycles after core_start
    sel = 0;
    run(4'h7, 3, {BL, BL, BL, 7'h78}, 16'd1, lat_exp(3));

    // history shifting, oldest dropped
    pulse_reset();
    for (int i = 0; i < 5; i++)
      run(vecs[i].digit, vecs[i].wait_n, vecs[i].exp_hex, vecs[i].exp_cnt, lat_exp(vecs[i].wait_n));

    // start held high plus extra edge while busy
    cs0 = cs_seen;
    @(negedge clk); set_start(1'b1);
    @(negedge clk); chk("hold_launch", m_cs, 1);
    @(negedge clk); set_start(1'b0);
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_done(1'b1, 4'h6);
    @(negedge clk); set_done(1'b0, 4'h0);
    @(negedge clk);
    chk("hold_busy_fall", m_busy, 0);
    chk("hold_hex", m_hex, {7'h30, 7'h19, 7'h12, 7'h02});
    chk("hold_cnt", m_cnt, 6);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("hold_no_retrigger_busy", m_busy, 0);
    chk("hold_one_core_start", cs_seen, cs0 + 1);
    set_start(1'b0);
    @(negedge clk); set_start(1'b1);
    @(negedge clk);
    chk("rearm_launch", m_cs, 1);
    chk("rearm_busy", m_busy, 1);
    set_start(1'b0);
    @(negedge clk); set_done(1'b1, 4'h8);
    @(negedge clk); set_done(1'b0, 4'h0);
    @(negedge clk);
    chk("rearm_hex", m_hex, {7'h19, 7'h12, 7'h02, 7'h00});
    chk("rearm_cnt", m_cnt, 7);

    // asynchronous reset mid-run
    pulse_reset();
    run(4'h3, 2, {BL, BL, BL, 7'h30}, 16'd1, lat_exp(2));
    run(4'h4, 1, {BL, BL, 7'h30, 7'h19}, 16'd2, lat_exp(1));
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_busy", m_busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", m_busy, 0);
    chk("mid_rst_hex", m_hex, blank);
    chk("mid_rst_cnt", m_cnt, 0);
    chk("mid_rst_rv", m_rv, 0);
    @(negedge clk); reset_n = 1'b1; set_start(1'b1);
    @(negedge clk);
    chk("launch_before_rst", m_cs, 1);
    #2 reset_n = 1'b0;
    #1 chk("rst_drops_core_start", m_cs, 0);
    @(negedge clk); reset_n = 1'b1; set_start(1'b0); set_done(1'b1, 4'h5);
    @(negedge clk); @(negedge clk); set_done(1'b0, 4'h0);
    @(negedge clk);
    chk("idle_done_busy", m_busy, 0);
    chk("idle_done_hex", m_hex, blank);
    chk("idle_done_cnt", m_cnt, 0);
    chk("idle_done_rv", m_rv, 0);

    // latency of 10 WAIT cycles
    run(4'hB, 10, {BL, BL, BL, 7'h03}, 16'd1, lat_exp(10));

    // watchdog on the 8-cycle instance
    sel = 1;
    pulse_reset();
    run(4'h9, 2, {BL, BL, BL, 7'h10}, 16'd1, lat_exp(2));
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    nbusy = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!m_busy) break;
      nbusy++;
    end
    chk("timeout_busy_cycles", nbusy, 9);
    chk("timeout_err_set", m_to, 1);
    chk("timeout_hex_kept", m_hex, {BL, BL, BL, 7'h10});
    chk("timeout_cnt_kept", m_cnt, 1);
    chk("timeout_lat_kept", m_lat, lat_exp(2));
    chk("timeout_no_rv", m_rv, 0);
    // done on the last allowed WAIT cycle wins; 8 saturates to 7 in a 3-bit field
    run(4'hA, 8, {BL, BL, 7'h10, 7'h08}, 16'd2, lat_exp(7));
    chk("done_wins_no_err", m_to, 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
